// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display driver and its BCD converter.
package score_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  // 10^n as an elaboration-time constant for the decimal overflow threshold
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; the first iteration is folded into the start edge
// so a VALUE_W-bit value finishes VALUE_W edges after start, with done pulsing once.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int unsigned VALUE_W    = 16,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    slw_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      value,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned ACC_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] sh_q, sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   adj_c;

  // Add-3 correction on every digit that is 5 or more
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_t d_c;
    assign d_c = acc_q[4*g +: 4];
    assign adj_c[4*g +: 4] = (d_c >= 4'd5) ? d_c + 4'd3 : d_c;
  end

  always_comb begin
    sh_d   = sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      acc_d = ACC_W'(value[VALUE_W-1]);
      sh_d  = {value[VALUE_W-2:0], 1'b0};
      cnt_d = CNT_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = {adj_c[ACC_W-2:0], sh_q[VALUE_W-1]};
      sh_d  = {sh_q[VALUE_W-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(VALUE_W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slw_clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/segment_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module segment_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'b1111111;
    case (digit)
      4'h0: seg_c = 7'b1000000;
      4'h1: seg_c = 7'b1111001;
      4'h2: seg_c = 7'b0100100;
      4'h3: seg_c = 7'b0110000;
      4'h4: seg_c = 7'b0011001;
      4'h5: seg_c = 7'b0010010;
      4'h6: seg_c = 7'b0000010;
      4'h7: seg_c = 7'b1111000;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0010000;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b0000011;
      4'hC: seg_c = 7'b1000110;
      4'hD: seg_c = 7'b0100001;
      4'hE: seg_c = 7'b0000110;
      4'hF: seg_c = 7'b0001110;
      default: seg_c = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/score_display_mux.sv
// Multiplexed N-digit seven-segment driver for game values with sequential BCD conversion,
// leading-zero blanking and overflow saturation. SCORE_DISP_HEX_EN adds a raw hex_mode path.
module score_display_mux
  import score_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned VALUE_W     = 16,
  parameter int unsigned REFRESH_DIV = 1
) (
  input  logic                  slw_clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lz,
`ifdef SCORE_DISP_HEX_EN
  input  logic                  hex_mode,
`endif
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an_cntrl,
  output logic [6:0]            seg_cntrl
);

  localparam int unsigned ACC_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [63:0] OVF_THRESH = pow10(NUM_DIGITS);

  conv_state_t                 state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        ovf_q, ovf_d;
  logic                        ovf_flag_q, ovf_flag_d;
  logic                        hex_q, hex_d;
  logic [ACC_W-1:0]            raw_q, raw_d;
  bcd_digit_t [NUM_DIGITS-1:0] digits_q, digits_d;
  logic                        pend_valid_q, pend_valid_d;
  logic [VALUE_W-1:0]          pend_value_q, pend_value_d;
  logic                        pend_hex_q, pend_hex_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PRE_W-1:0]            presc_q, presc_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                  seg_q, seg_d;

  logic                  hex_in_c, next_hex_c, take_c, start_c, bcd_done_c;
  logic [VALUE_W-1:0]    next_val_c;
  logic [63:0]           next_wide_c;
  logic [ACC_W-1:0]      bcd_c;
  logic [NUM_DIGITS-1:0] zero_c, lz_c;
  logic [6:0]            dec_seg_c;
  bcd_digit_t            cur_digit_c;

`ifdef SCORE_DISP_HEX_EN
  assign hex_in_c = hex_mode;
`else
  assign hex_in_c = 1'b0;
`endif

  // A load arriving in the same cycle beats the pending entry (latest wins)
  assign next_val_c  = load ? value : pend_value_q;
  assign next_hex_c  = load ? hex_in_c : pend_hex_q;
  assign next_wide_c = 64'(next_val_c);

  bin2bcd_seq #(
    .VALUE_W   (VALUE_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .slw_clk(slw_clk),
    .rst    (rst),
    .start  (start_c),
    .value  (next_val_c),
    .done   (bcd_done_c),
    .bcd    (bcd_c)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    ovf_d        = ovf_q;
    ovf_flag_d   = ovf_flag_q;
    hex_d        = hex_q;
    raw_d        = raw_q;
    digits_d     = digits_q;
    pend_valid_d = pend_valid_q;
    pend_value_d = pend_value_q;
    pend_hex_d   = pend_hex_q;
    take_c       = 1'b0;
    start_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) take_c = 1'b1;
      end
      SHIFT: begin
        if (load) begin
          pend_valid_d = 1'b1;
          pend_value_d = value;
          pend_hex_d   = hex_in_c;
        end
        if (bcd_done_c) state_d = COMMIT;
      end
      COMMIT: begin
        if (ovf_flag_q) digits_d = hex_q ? {NUM_DIGITS{4'hF}} : {NUM_DIGITS{4'h9}};
        else            digits_d = hex_q ? raw_q : bcd_c;
        ovf_d        = ovf_flag_q;
        pend_valid_d = 1'b0;
        if (load || pend_valid_q) begin
          take_c = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Start a new conversion from the selected source
    if (take_c) begin
      busy_d     = 1'b1;
      hex_d      = next_hex_c;
      raw_d      = ACC_W'(next_val_c);
      ovf_flag_d = next_hex_c ? ((next_wide_c >> ACC_W) != 64'd0) : (next_wide_c >= OVF_THRESH);
      start_c    = !next_hex_c;
      state_d    = next_hex_c ? COMMIT : SHIFT;
    end
  end

  // Leading-zero map: a digit is blankable when it and every higher digit are zero
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    assign zero_c[g] = (digits_q[g] == 4'd0);
    if (g == 0) begin : g_ones
      assign lz_c[g] = 1'b0;
    end else begin : g_upper
      assign lz_c[g] = &zero_c[NUM_DIGITS-1:g];
    end
  end

  assign cur_digit_c = digits_q[idx_q];

  segment_decoder u_seg_dec (
    .digit(cur_digit_c),
    .seg_c(dec_seg_c)
  );

  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = (blank_lz && lz_c[idx_q]) ? SEG_BLANK : dec_seg_c;
  end

  always_ff @(posedge slw_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ovf_flag_q   <= 1'b0;
      hex_q        <= 1'b0;
      raw_q        <= '0;
      digits_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_value_q <= '0;
      pend_hex_q   <= 1'b0;
      idx_q        <= '0;
      presc_q      <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      ovf_flag_q   <= ovf_flag_d;
      hex_q        <= hex_d;
      raw_q        <= raw_d;
      digits_q     <= digits_d;
      pend_valid_q <= pend_valid_d;
      pend_value_q <= pend_value_d;
      pend_hex_q   <= pend_hex_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign an_cntrl  = an_q;
  assign seg_cntrl = seg_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Directed self-checking bench: default 4-digit instance plus a 3-digit, divide-by-4 instance.
`timescale 1ns/1ps
module tb_score_display_mux;

  logic        clk;
  logic        rst;
  logic [15:0] value0, value1;
  logic        load0, load1, blank0, blank1;
  logic        busy0, busy1, ovf0, ovf1;
  logic [3:0]  an0;
  logic [2:0]  an1;
  logic [6:0]  seg0, seg1;

  int checks = 0;
  int fails  = 0;
  logic [6:0] seen [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  score_display_mux #(.NUM_DIGITS(4), .VALUE_W(16), .REFRESH_DIV(1)) u0 (
    .slw_clk(clk), .rst(rst), .value(value0), .load(load0), .blank_lz(blank0),
`ifdef SCORE_DISP_HEX_EN
    .hex_mode(1'b0),
`endif
    .busy(busy0), .overflow(ovf0), .an_cntrl(an0), .seg_cntrl(seg0)
  );

  score_display_mux #(.NUM_DIGITS(3), .VALUE_W(16), .REFRESH_DIV(4)) u1 (
    .slw_clk(clk), .rst(rst), .value(value1), .load(load1), .blank_lz(blank1),
`ifdef SCORE_DISP_HEX_EN
    .hex_mode(1'b0),
`endif
    .busy(busy1), .overflow(ovf1), .an_cntrl(an1), .seg_cntrl(seg1)
  );

  // Active-low {g,f,e,d,c,b,a} codes for decimal digits
  function automatic logic [6:0] segx(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record the segment pattern shown on each anode over a number of cycles
  task automatic capture(input int inst, input int cycles);
    for (int k = 0; k < 8; k++) seen[k] = 7'bx;
    for (int c = 0; c < cycles; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (inst == 0 && an0 == ~(4'b0001 << i)) seen[i] = seg0;
        if (inst == 1 && i < 3 && an1 == ~(3'b001 << i)) seen[i] = seg1;
      end
    end
  endtask

  task automatic do_load(input int inst, input logic [15:0] v);
    @(negedge clk);
    if (inst == 0) begin value0 = v; load0 = 1'b1; end
    else begin value1 = v; load1 = 1'b1; end
    tick();
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    while (((inst == 0) ? busy0 : busy1) === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (n >= 200) begin
      fails++;
      $display("FAIL wait_idle inst%0d: still busy after %0d cycles, required idle", inst, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load0 = 1'b0; load1 = 1'b0; blank0 = 1'b0; blank1 = 1'b0;
    value0 = '0; value1 = '0;
    #1 rst = 1'b1;
    #2;
    checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf0); end
    checks++; if (an0 !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b expected 1111", an0); end
    checks++; if (seg0 !== 7'b1111111) begin fails++; $display("FAIL reset_seg: got %b expected 1111111", seg0); end
    checks++; if (an1 !== 3'b111) begin fails++; $display("FAIL reset_an1: got %b expected 111", an1); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if (an0 !== 4'b1110) begin fails++; $display("FAIL first_an: got %b expected 1110", an0); end
    checks++; if (seg0 !== segx(0)) begin fails++; $display("FAIL first_seg: got %b expected %b", seg0, segx(0)); end
    capture(0, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== segx(0)) begin fails++; $display("FAIL reset_digit%0d: got %b expected %b", i, seen[i], segx(0)); end
    end
  endtask

  task automatic test_convert_1234();
    int n;
    logic [3:0] a [4];
    logic [6:0] exp [4];
    exp[0] = segx(4); exp[1] = segx(3); exp[2] = segx(2); exp[3] = segx(1);
    blank0 = 1'b0;
    @(negedge clk); value0 = 16'd1234; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n !== 17) begin fails++; $display("FAIL busy_len_1234: got %0d expected 17", n); end
    checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL ovf_1234: got %b expected 0", ovf0); end
    capture(0, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== exp[i]) begin fails++; $display("FAIL digit1234_%0d: got %b expected %b", i, seen[i], exp[i]); end
    end
    for (int k = 0; k < 4; k++) begin tick(); a[k] = an0; end
    checks++;
    if ($countones(~a[0]) != 1) begin fails++; $display("FAIL an_onehot: got %b expected one low bit", a[0]); end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (a[k] !== {a[k-1][2:0], a[k-1][3]}) begin
        fails++; $display("FAIL an_order%0d: got %b expected %b", k, a[k], {a[k-1][2:0], a[k-1][3]});
      end
    end
  endtask

  task automatic test_blank();
    blank0 = 1'b1;
    do_load(0, 16'd42);
    wait_idle(0);
    capture(0, 4);
    checks++; if (seen[0] !== segx(2)) begin fails++; $display("FAIL blank42_d0: got %b expected %b", seen[0], segx(2)); end
    checks++; if (seen[1] !== segx(4)) begin fails++; $display("FAIL blank42_d1: got %b expected %b", seen[1], segx(4)); end
    checks++; if (seen[2] !== 7'h7F) begin fails++; $display("FAIL blank42_d2: got %b expected 1111111", seen[2]); end
    checks++; if (seen[3] !== 7'h7F) begin fails++; $display("FAIL blank42_d3: got %b expected 1111111", seen[3]); end
    blank0 = 1'b0;
    capture(0, 4);
    checks++; if (seen[0] !== segx(2)) begin fails++; $display("FAIL noblank42_d0: got %b expected %b", seen[0], segx(2)); end
    checks++; if (seen[2] !== segx(0)) begin fails++; $display("FAIL noblank42_d2: got %b expected %b", seen[2], segx(0)); end
    checks++; if (seen[3] !== segx(0)) begin fails++; $display("FAIL noblank42_d3: got %b expected %b", seen[3], segx(0)); end
    blank0 = 1'b1;
    do_load(0, 16'd0);
    wait_idle(0);
    capture(0, 4);
    checks++; if (seen[0] !== segx(0)) begin fails++; $display("FAIL blank0_d0: got %b expected %b", seen[0], segx(0)); end
    checks++; if (seen[1] !== 7'h7F) begin fails++; $display("FAIL blank0_d1: got %b expected 1111111", seen[1]); end
    blank0 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] vals [3];
    logic        ovfs [3];
    vals[0] = 16'd12345; ovfs[0] = 1'b1;
    vals[1] = 16'd9999;  ovfs[1] = 1'b0;
    vals[2] = 16'd10000; ovfs[2] = 1'b1;
    blank0 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_load(0, vals[t]);
      wait_idle(0);
      checks++;
      if (ovf0 !== ovfs[t]) begin fails++; $display("FAIL ovf_%0d: got %b expected %b", vals[t], ovf0, ovfs[t]); end
      capture(0, 4);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== segx(9)) begin fails++; $display("FAIL sat_%0d_d%0d: got %b expected %b", vals[t], i, seen[i], segx(9)); end
      end
    end
    blank0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    bit saw1, saw2;
    saw1 = 1'b0; saw2 = 1'b0;
    blank0 = 1'b0;
    @(negedge clk); value0 = 16'd100; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin
      if (n == 3) begin value0 = 16'd200; load0 = 1'b1; end
      else if (n == 6) begin value0 = 16'd300; load0 = 1'b1; end
      else load0 = 1'b0;
      if (an0 == 4'b1011 && seg0 == segx(1)) saw1 = 1'b1;
      if (an0 == 4'b1011 && seg0 == segx(2)) saw2 = 1'b1;
      n++;
      tick();
    end
    load0 = 1'b0;
    checks++; if (n !== 34) begin fails++; $display("FAIL busy_len_b2b: got %0d expected 34", n); end
    checks++; if (saw1 !== 1'b1) begin fails++; $display("FAIL shown_100: got %b expected 1", saw1); end
    capture(0, 4);
    for (int i = 0; i < 4; i++) if (an0 == 4'b1011 && seg0 == segx(2)) saw2 = 1'b1;
    checks++; if (saw2 !== 1'b0) begin fails++; $display("FAIL shown_200: got %b expected 0", saw2); end
    checks++; if (seen[2] !== segx(3)) begin fails++; $display("FAIL b2b_d2: got %b expected %b", seen[2], segx(3)); end
    checks++; if (seen[0] !== segx(0)) begin fails++; $display("FAIL b2b_d0: got %b expected %b", seen[0], segx(0)); end
    checks++; if (seen[3] !== segx(0)) begin fails++; $display("FAIL b2b_d3: got %b expected %b", seen[3], segx(0)); end
  endtask

  task automatic test_reset_abort();
    bit went_busy;
    blank0 = 1'b0;
    @(negedge clk); value0 = 16'd5555; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n == 2) begin value0 = 16'd6666; load0 = 1'b1; end
      else load0 = 1'b0;
      tick();
    end
    load0 = 1'b0;
    checks++; if (busy0 !== 1'b1) begin fails++; $display("FAIL abort_prebusy: got %b expected 1", busy0); end
    rst = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy0); end
    checks++; if (an0 !== 4'b1111) begin fails++; $display("FAIL abort_an: got %b expected 1111", an0); end
    @(negedge clk) rst = 1'b0;
    went_busy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (busy0 !== 1'b0) went_busy = 1'b1;
    end
    checks++; if (went_busy !== 1'b0) begin fails++; $display("FAIL abort_pending: got %b expected 0", went_busy); end
    checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL abort_ovf: got %b expected 0", ovf0); end
    capture(0, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== segx(0)) begin fails++; $display("FAIL abort_d%0d: got %b expected %b", i, seen[i], segx(0)); end
    end
    blank0 = 1'b1;
    do_load(0, 16'd7);
    wait_idle(0);
    capture(0, 4);
    checks++; if (seen[0] !== segx(7)) begin fails++; $display("FAIL after_abort_d0: got %b expected %b", seen[0], segx(7)); end
    checks++; if (seen[3] !== 7'h7F) begin fails++; $display("FAIL after_abort_d3: got %b expected 1111111", seen[3]); end
    blank0 = 1'b0;
  endtask

  task automatic test_scan_div4();
    logic [2:0] pat [3];
    logic [2:0] exp;
    pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;
    blank1 = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = pat[((k - 1) / 4) % 3];
      checks++;
      if (an1 !== exp) begin fails++; $display("FAIL div4_an_cyc%0d: got %b expected %b", k, an1, exp); end
    end
    do_load(1, 16'd999);
    wait_idle(1);
    checks++; if (ovf1 !== 1'b0) begin fails++; $display("FAIL ovf1_999: got %b expected 0", ovf1); end
    capture(1, 12);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (seen[i] !== segx(9)) begin fails++; $display("FAIL n3_999_d%0d: got %b expected %b", i, seen[i], segx(9)); end
    end
    do_load(1, 16'd1000);
    wait_idle(1);
    checks++; if (ovf1 !== 1'b1) begin fails++; $display("FAIL ovf1_1000: got %b expected 1", ovf1); end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_blank();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_scan_div4();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
